// File: rtl/ram_port_pkg.sv
// rtl/ram_port_pkg.sv - shared state encoding and RAM timing constants for ram_port_master
// Purpose : state type and fixed RAM read latency shared by the RAM initiator files.
// Contents: state_t (3-bit FSM encoding), RAM_RD_LAT.
package ram_port_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR      = 3'd1,
      ST_RD_ADDR = 3'd2,
      ST_RD_DATA = 3'd3,
      ST_RESP    = 3'd4
   } state_t;

   // RAM dout is registered once: address sampled at one edge, data valid the next cycle.
   localparam int RAM_RD_LAT = 1;

endpackage

// File: rtl/ram_port_master_sat_counter.sv
// rtl/ram_port_master_sat_counter.sv - saturating event counter used for access statistics
// Purpose : counts i_inc pulses, sticks at all-ones instead of wrapping.
// Ports   : clk, reset (async, active-high), i_inc (count enable), o_count (current value).
module sat_counter #(
   parameter int width = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_inc,
   output logic [width-1:0] o_count
);

   logic [width-1:0] r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {width{1'b1}})) begin
         r_count <= r_count + width'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/ram_port_master.sv
// rtl/ram_port_master.sv - valid/ready request stream to single-port-pair synchronous RAM initiator
// Purpose : serialises read/write requests into RAM accesses and returns read data on a
//           valid/ready response stream; keeps read/write/statistics counters.
// Ports   : clk, reset (async, active-high)
//           req_valid/req_ready/req_write/req_addr/req_wdata : request stream
//           rsp_valid/rsp_ready/rsp_rdata                    : response stream (reads only)
//           ram_read_address/ram_write_address/ram_write/ram_din/ram_dout : RAM side
//           busy, rd_count, wr_count                         : status
module ram_port_master
   import ram_port_pkg::*;
#(
   parameter int data_width = 32,
   parameter int addr_width = 4,
   parameter int cnt_width  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [addr_width-1:0] req_addr,
   input  logic [data_width-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [data_width-1:0] rsp_rdata,
   output logic [addr_width-1:0] ram_read_address,
   output logic [addr_width-1:0] ram_write_address,
   output logic                  ram_write,
   output logic [data_width-1:0] ram_din,
   input  logic [data_width-1:0] ram_dout,
   output logic                  busy,
   output logic [cnt_width-1:0]  rd_count,
   output logic [cnt_width-1:0]  wr_count
);

   state_t                r_state;
   state_t                w_next;
   logic                  w_req_fire;
   logic                  w_rsp_fire;
   logic                  r_rsp_valid;
   logic [data_width-1:0] r_rsp_rdata;
   logic [addr_width-1:0] r_rd_addr;
   logic [addr_width-1:0] r_wr_addr;
   logic                  r_write;
   logic [data_width-1:0] r_din;

   // Gating with reset keeps req_ready low for the whole time reset is held.
   assign req_ready  = (r_state == ST_IDLE) && !reset;
   assign busy       = (r_state != ST_IDLE);
   assign w_req_fire = req_valid && req_ready;
   assign w_rsp_fire = r_rsp_valid && rsp_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_req_fire) begin
               w_next = req_write ? ST_WR : ST_RD_ADDR;
            end
         end
         ST_WR:      w_next = ST_IDLE;
         ST_RD_ADDR: w_next = ST_RD_DATA;
         ST_RD_DATA: w_next = ST_RESP;
         ST_RESP: begin
            if (w_rsp_fire) begin
               w_next = ST_IDLE;
            end
         end
         default:    w_next = ST_IDLE;
      endcase
   end

   // Address/data registers load only on an accepted request so they hold
   // their last value otherwise. ram_write is high only for the WR cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_write     <= 1'b0;
         r_wr_addr   <= '0;
         r_rd_addr   <= '0;
         r_din       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_write <= (r_state == ST_IDLE) && w_req_fire && req_write;
         if ((r_state == ST_IDLE) && w_req_fire) begin
            if (req_write) begin
               r_wr_addr <= req_addr;
               r_din     <= req_wdata;
            end else begin
               r_rd_addr <= req_addr;
            end
         end
         if (r_state == ST_RD_DATA) begin
            r_rsp_rdata <= ram_dout;
            r_rsp_valid <= 1'b1;
         end else if ((r_state == ST_RESP) && w_rsp_fire) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

   assign ram_write         = r_write;
   assign ram_write_address = r_wr_addr;
   assign ram_read_address  = r_rd_addr;
   assign ram_din           = r_din;
   assign rsp_valid         = r_rsp_valid;
   assign rsp_rdata         = r_rsp_rdata;

   // A write completes at the edge closing WR; a read completes when its data is captured.
   sat_counter #(.width(cnt_width)) u_wr_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_inc   (r_state == ST_WR),
      .o_count (wr_count)
   );

   sat_counter #(.width(cnt_width)) u_rd_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_inc   (r_state == ST_RD_DATA),
      .o_count (rd_count)
   );

endmodule

// File: tb/tb_ram_port_master.sv
// tb/tb_ram_port_master.sv - self-checking bench for ram_port_master with a behavioural RAM behind it
module tb_ram_port_master;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_write = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_rdata;
   logic [AW-1:0] ram_read_address;
   logic [AW-1:0] ram_write_address;
   logic          ram_write;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;
   logic          busy;
   logic [CW-1:0] rd_count;
   logic [CW-1:0] wr_count;

   logic [DW-1:0] mem [2**AW];
   logic [DW-1:0] exp_mem [2**AW];
   logic [DW-1:0] sb_q [$];
   int            n_tests = 0;
   int            n_fail = 0;
   int            cyc = 0;
   int            acc_cyc = 0;
   int            exp_wr = 0;
   int            exp_rd = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural RAM: registered dout, one-cycle read latency.
   always @(posedge clk) begin
      if (ram_write) mem[ram_write_address] <= ram_din;
      ram_dout <= mem[ram_read_address];
   end

   ram_port_master #(.data_width(DW), .addr_width(AW), .cnt_width(CW)) dut (
      .clk               (clk),
      .reset             (reset),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_write         (req_write),
      .req_addr          (req_addr),
      .req_wdata         (req_wdata),
      .rsp_valid         (rsp_valid),
      .rsp_ready         (rsp_ready),
      .rsp_rdata         (rsp_rdata),
      .ram_read_address  (ram_read_address),
      .ram_write_address (ram_write_address),
      .ram_write         (ram_write),
      .ram_din           (ram_din),
      .ram_dout          (ram_dout),
      .busy              (busy),
      .rd_count          (rd_count),
      .wr_count          (wr_count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic int sat_inc(input int v);
      return (v >= (2**CW - 1)) ? v : v + 1;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_outs"}, {req_ready, rsp_valid, ram_write, busy}, 4'b0);
      check({tag, "_rdata"}, rsp_rdata, 0);
      check({tag, "_addr"}, {ram_read_address, ram_write_address}, 0);
      check({tag, "_din"}, ram_din, 0);
      check({tag, "_cnt"}, {rd_count, wr_count}, 0);
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
      check("wr_ready_idle", req_ready, 1);
      tick();
      acc_cyc = cyc;
      req_valid = 1'b0; req_wdata = '0;
      check("wr_pulse", ram_write, 1);
      check("wr_addr", ram_write_address, a);
      check("wr_din", ram_din, d);
      check("wr_ready_low", req_ready, 0);
      tick();
      exp_mem[a] = d;
      exp_wr = sat_inc(exp_wr);
      check("wr_pulse_end", ram_write, 0);
      check("wr_count", wr_count, exp_wr);
      check("wr_ram_word", mem[a], d);
   endtask

   task automatic do_read(input logic [AW-1:0] a, input int hold);
      int n;
      logic [DW-1:0] held;
      logic [DW-1:0] e;
      req_valid = 1'b1; req_write = 1'b0; req_addr = a;
      check("rd_ready_idle", req_ready, 1);
      sb_q.push_back(exp_mem[a]);
      tick();
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 8) begin
         tick();
         n++;
      end
      check("rd_latency", n, 2);
      e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
      check("rd_data", rsp_rdata, e);
      exp_rd = sat_inc(exp_rd);
      check("rd_count", rd_count, exp_rd);
      held = rsp_rdata;
      for (int i = 0; i < hold; i++) begin
         tick();
         check("bp_valid", rsp_valid, 1);
         check("bp_data", rsp_rdata, held);
         check("bp_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("rsp_drop", rsp_valid, 0);
      check("rsp_idle", {busy, req_ready}, 2'b01);
   endtask

   initial begin
      int a0;
      for (int i = 0; i < 2**AW; i++) begin
         mem[i] = DW'(i);
         exp_mem[i] = DW'(i);
      end

      // Reset state
      #1;
      check_all_zero("reset");
      tick();
      reset = 1'b0;
      #1;
      check("post_reset_ready", {busy, req_ready}, 2'b01);
      @(negedge clk);

      // Write then read-after-write
      do_write(4'd3, 32'hDEADBEEF);
      do_read(4'd3, 0);

      // Backpressure on preloaded word
      do_read(4'd5, 4);

      // Back-to-back writes at address extremes
      do_write(4'd15, 32'h11);
      a0 = acc_cyc;
      do_write(4'd0, 32'h22);
      check("wr_spacing", acc_cyc - a0, 2);
      do_read(4'd15, 0);
      do_read(4'd0, 1);

      // Reset during RD_DATA: response discarded
      req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd7;
      tick();
      req_valid = 1'b0;
      tick();
      check("mid_rd_busy", busy, 1);
      reset = 1'b1;
      #1;
      check_all_zero("rst_rd");
      exp_wr = 0; exp_rd = 0;
      @(negedge clk);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("no_rsp_after_rst", rsp_valid, 0);
      end

      // Reset during WR: write aborted
      req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd9; req_wdata = 32'hBAD0BAD0;
      tick();
      req_valid = 1'b0;
      check("mid_wr_pulse", ram_write, 1);
      reset = 1'b1;
      #1;
      check_all_zero("rst_wr");
      @(negedge clk);
      tick();
      reset = 1'b0;
      tick();
      check("aborted_wr_ram", mem[9], exp_mem[9]);
      do_read(4'd9, 0);

      // Counter saturation
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_wr = 0; exp_rd = 0;
      tick();
      for (int i = 0; i < 5; i++) begin
         do_write(AW'(i + 1), DW'(32'hA0 + i));
      end
      check("wr_sat_final", wr_count, 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
